muldiv_hilo_ctrl: RTL and testbench



---
 rtl/muldiv_hilo_ctrl_if.sv | 23 ++
 rtl/muldiv_hilo_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_hilo_ctrl_if.sv
// Execute-stage <-> HI/LO sequencer bundle: operation request, pipeline hold and HI/LO write bus.
// master = execute stage / pipeline control, slave = muldiv_hilo_ctrl.
interface muldiv_hilo_ctrl_if;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic        HiLoRead;
    logic        Busy;
    logic        Done;
    logic        Stall;
    logic [63:0] HiLoData;

    modport master (
        output Start, Op, OpA, OpB, HiLoRead,
        input  Busy, Done, Stall, HiLoData
    );

    modport slave (
        input  Start, Op, OpA, OpB, HiLoRead,
        output Busy, Done, Stall, HiLoData
    );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// MIPS HI/LO sequencer: iterative shift-add multiply, restoring divide, MTHI/MTLO, pipeline stall.
// Optional build macro MULDIV_FAST_MULT_EN: single-cycle multiply instead of 32 iterations.
module muldiv_hilo_ctrl #(
    parameter logic [31:0] RESET_HI = 32'h0000_0000,
    parameter logic [31:0] RESET_LO = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_hilo_ctrl_if.slave bus
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

`ifdef MULDIV_FAST_MULT_EN
    localparam state_t MUL_ENTRY = S_FIX;
`else
    localparam state_t MUL_ENTRY = S_MUL;
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opd;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_is_div;
    logic        r_neg_res;
    logic        r_neg_rem;

    logic        w_accept;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_b_zero;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_cand;
    logic        w_div_ge;
    logic [31:0] w_div_rem;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] w_fast_prod;
`endif

    // Request decode and operand magnitude/sign extraction
    always_comb begin
        w_accept = (r_state == S_IDLE) && bus.Start && (bus.Op <= OP_MTLO);
        w_is_mul = (bus.Op == OP_MULT) || (bus.Op == OP_MULTU);
        w_is_div = (bus.Op == OP_DIV) || (bus.Op == OP_DIVU);
        w_signed = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
        w_a_neg  = w_signed && bus.OpA[31];
        w_b_neg  = w_signed && bus.OpB[31];
        w_a_abs  = w_a_neg ? (32'd0 - bus.OpA) : bus.OpA;
        w_b_abs  = w_b_neg ? (32'd0 - bus.OpB) : bus.OpB;
        w_b_zero = (bus.OpB == 32'd0);
`ifdef MULDIV_FAST_MULT_EN
        w_fast_prod = {32'd0, w_a_abs} * {32'd0, w_b_abs};
`endif
    end

    // One iteration step for each engine plus the final sign correction
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opd : 32'd0)};
        w_div_cand = {r_acc[63:32], r_acc[31]};
        w_div_ge   = (w_div_cand >= {1'b0, r_opd});
        w_div_rem  = w_div_ge ? (w_div_cand[31:0] - r_opd) : w_div_cand[31:0];
        w_prod_fix = r_neg_res ? (64'd0 - r_acc) : r_acc;
        w_quo_fix  = r_neg_res ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
        w_rem_fix  = r_neg_rem ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    end

    // Next-state selection
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_next_state = MUL_ENTRY;
                end else if (w_accept && w_is_div) begin
                    w_next_state = w_b_zero ? S_FIX : S_DIV;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_MUL: begin
                if (r_cnt == 5'd31) begin
                    w_next_state = S_FIX;
                end else begin
                    w_next_state = S_MUL;
                end
            end
            S_DIV: begin
                if (r_cnt == 5'd31) begin
                    w_next_state = S_FIX;
                end else begin
                    w_next_state = S_DIV;
                end
            end
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath, architectural HI/LO and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi      <= RESET_HI;
            r_lo      <= RESET_LO;
            r_opd     <= 32'd0;
            r_acc     <= 64'd0;
            r_cnt     <= 5'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= 5'd0;
                        case (bus.Op)
                            OP_MTHI: r_hi <= bus.OpA;
                            OP_MTLO: r_lo <= bus.OpA;
                            OP_MULT, OP_MULTU: begin
                                r_busy    <= 1'b1;
                                r_is_div  <= 1'b0;
                                r_neg_res <= w_a_neg ^ w_b_neg;
                                r_neg_rem <= 1'b0;
                                r_opd     <= w_a_abs;
`ifdef MULDIV_FAST_MULT_EN
                                r_acc     <= w_fast_prod;
`else
                                r_acc     <= {32'd0, w_b_abs};
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                r_busy   <= 1'b1;
                                r_is_div <= 1'b1;
                                r_opd    <= w_b_abs;
                                // Divide by zero preloads the final {HI, LO} and bypasses the iterations
                                if (w_b_zero) begin
                                    r_acc     <= {bus.OpA, 32'hFFFF_FFFF};
                                    r_neg_res <= 1'b0;
                                    r_neg_rem <= 1'b0;
                                end else begin
                                    r_acc     <= {32'd0, w_a_abs};
                                    r_neg_res <= w_a_neg ^ w_b_neg;
                                    r_neg_rem <= w_a_neg;
                                end
                            end
                            default: r_cnt <= 5'd0;
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc <= {w_mul_sum, r_acc[31:1]};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_DIV: begin
                    r_acc <= {w_div_rem, r_acc[30:0], w_div_ge};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[63:32];
                        r_lo <= w_prod_fix[31:0];
                    end
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign bus.Busy     = r_busy;
    assign bus.Done     = r_done;
    assign bus.Stall    = r_busy & (bus.HiLoRead | bus.Start);
    assign bus.HiLoData = {r_hi, r_lo};

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl: directed cases plus randomized ops against an arithmetic reference model.
module tb_muldiv_hilo_ctrl;

    logic clk;
    logic rst;
    muldiv_hilo_ctrl_if bus();

    muldiv_hilo_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural result of one operation using plain integer arithmetic
    function automatic logic [63:0] ref_hilo(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] hi, input logic [31:0] lo);
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned uq;
        longint unsigned ur;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: p = 64'(sa * sb);
            3'd1: p = 64'(ua * ub);
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (op == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    p = {ur[31:0], uq[31:0]};
                end
            end
            3'd4:    p = {a, lo};
            3'd5:    p = {hi, a};
            default: p = {hi, lo};
        endcase
        return p;
    endfunction

    // Expected number of cycles with Busy high
    function automatic int ref_busy(input logic [2:0] op, input logic [31:0] b);
        if (op <= 3'd1) begin
`ifdef MULDIV_FAST_MULT_EN
            return 1;
`else
            return 33;
`endif
        end else if (op <= 3'd3) begin
            return (b == 32'd0) ? 1 : 33;
        end else begin
            return 0;
        end
    endfunction

    // Issue one op (Start accepted at the next posedge) and observe until Done or timeout
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cyc, output bit done_seen, output logic [63:0] data);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.OpA   = a;
        bus.OpB   = b;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        busy_cyc  = 0;
        done_seen = 1'b0;
        if (op >= 3'd4) begin
            @(negedge clk);
            busy_cyc  = int'(bus.Busy);
            done_seen = bus.Done;
        end else begin
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (bus.Done) begin
                    done_seen = 1'b1;
                    break;
                end
                if (bus.Busy) busy_cyc++;
            end
        end
        data = bus.HiLoData;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.Start    = 1'b1;
        bus.Op       = 3'd0;
        bus.OpA      = 32'h1111_1111;
        bus.OpB      = 32'h2222_2222;
        bus.HiLoRead = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
        n_checks++; if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.Done); end
        n_checks++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.Stall); end
        n_checks++; if (bus.HiLoData !== 64'd0) begin n_fail++; $display("FAIL reset_hilo: got %h expected 0", bus.HiLoData); end
        rst          = 1'b0;
        bus.Start    = 1'b0;
        bus.HiLoRead = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_mult();
        int          bc;
        bit          ds;
        logic [63:0] d;
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, bc, ds, d);
        n_checks++; if (ds !== 1'b1) begin n_fail++; $display("FAIL mult_done: got %b expected 1", ds); end
        n_checks++; if (d !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_fail++; $display("FAIL mult_result: got %h expected ffffffff_fffffffa", d); end
        n_checks++; if (bc != ref_busy(3'd0, 32'd3)) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected %0d", bc, ref_busy(3'd0, 32'd3)); end
        @(negedge clk);
        n_checks++; if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse: got %b expected 0", bus.Done); end
        {m_hi, m_lo} = d;
    endtask

    task automatic test_divide();
        int          bc;
        bit          ds;
        logic [63:0] d;
        run_op(3'd3, 32'd100, 32'd7, bc, ds, d);
        n_checks++; if (d !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL divu_result: got %h expected 00000002_0000000e", d); end
        n_checks++; if (bc != 33 || ds !== 1'b1) begin n_fail++; $display("FAIL divu_timing: got busy %0d done %b expected 33/1", bc, ds); end
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, bc, ds, d);
        n_checks++; if (d !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_signed: got %h expected ffffffff_fffffffd", d); end
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc, ds, d);
        n_checks++; if (d !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL div_overflow: got %h expected 00000000_80000000", d); end
        {m_hi, m_lo} = d;
    endtask

    task automatic test_div_zero();
        int          bc;
        bit          ds;
        logic [63:0] d;
        run_op(3'd2, 32'h0000_1234, 32'd0, bc, ds, d);
        n_checks++; if (d !== 64'h0000_1234_FFFF_FFFF) begin n_fail++; $display("FAIL div0_result: got %h expected 00001234_ffffffff", d); end
        n_checks++; if (bc != 1 || ds !== 1'b1) begin n_fail++; $display("FAIL div0_timing: got busy %0d done %b expected 1/1", bc, ds); end
        {m_hi, m_lo} = d;
    endtask

    task automatic test_mthi_mtlo();
        int          bc0;
        int          bc1;
        bit          ds0;
        bit          ds1;
        logic [63:0] d;
        run_op(3'd4, 32'hA5A5_0000, 32'd0, bc0, ds0, d);
        run_op(3'd5, 32'h0000_5A5A, 32'd0, bc1, ds1, d);
        n_checks++; if (d !== 64'hA5A5_0000_0000_5A5A) begin n_fail++; $display("FAIL mthi_mtlo_result: got %h expected a5a50000_00005a5a", d); end
        n_checks++; if (bc0 != 0 || bc1 != 0 || ds0 || ds1) begin n_fail++; $display("FAIL mthi_mtlo_busy: got busy %0d/%0d done %b/%b expected 0", bc0, bc1, ds0, ds1); end
        {m_hi, m_lo} = d;
    endtask

    task automatic test_stall();
        int          st_cyc;
        bit          ds;
        bit          moved;
        logic [63:0] pre;
        logic [63:0] d;
        pre          = {m_hi, m_lo};
        st_cyc       = 0;
        ds           = 1'b0;
        moved        = 1'b0;
        bus.Start    = 1'b1;
        bus.Op       = 3'd1;
        bus.OpA      = 32'hFFFF_FFFF;
        bus.OpB      = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.Op       = 3'd5;
        bus.OpA      = 32'h1357_9BDF;
        bus.HiLoRead = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.Done) begin
                ds = 1'b1;
                break;
            end
            if (bus.Stall) st_cyc++;
            if (bus.HiLoData !== pre) moved = 1'b1;
        end
        d = bus.HiLoData;
        n_checks++; if (ds !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b expected 1", ds); end
        n_checks++; if (st_cyc != ref_busy(3'd1, 32'hFFFF_FFFF)) begin n_fail++; $display("FAIL stall_cycles: got %0d expected %0d", st_cyc, ref_busy(3'd1, 32'hFFFF_FFFF)); end
        n_checks++; if (moved) begin n_fail++; $display("FAIL stall_hold: got HiLoData change during Busy expected none"); end
        n_checks++; if (d !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL multu_max: got %h expected fffffffe_00000001", d); end
        n_checks++; if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b expected 0", bus.Stall); end
        @(posedge clk);
        #1;
        bus.Start    = 1'b0;
        bus.HiLoRead = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.HiLoData !== 64'hFFFF_FFFE_1357_9BDF) begin n_fail++; $display("FAIL held_start: got %h expected fffffffe_13579bdf", bus.HiLoData); end
        m_hi = 32'hFFFF_FFFE;
        m_lo = 32'h1357_9BDF;
    endtask

    task automatic test_back_to_back();
        int          bc;
        bit          ds;
        logic [63:0] d;
        logic [63:0] e;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       a = 32'h8000_0000;
                2:       b = 32'($urandom_range(1, 9));
                3:       b = 32'hFFFF_FFFF;
                default: b = b;
            endcase
            e = ref_hilo(op, a, b, m_hi, m_lo);
            run_op(op, a, b, bc, ds, d);
            n_checks++; if (d !== e) begin n_fail++; $display("FAIL rand_result op%0d a=%h b=%h: got %h expected %h", op, a, b, d, e); end
            n_checks++; if (bc != ref_busy(op, b) || ds !== (op <= 3'd3)) begin n_fail++; $display("FAIL rand_timing op%0d b=%h: got busy %0d done %b expected %0d/%b", op, b, bc, ds, ref_busy(op, b), (op <= 3'd3)); end
            {m_hi, m_lo} = e;
        end
    endtask

    task automatic test_reset_mid_div();
        int dn;
        int bz;
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Op    = 3'd2;
        bus.OpA   = 32'hDEAD_BEEF;
        bus.OpB   = 32'h0000_0013;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", bus.Busy); end
        n_checks++; if (bus.HiLoData !== 64'd0) begin n_fail++; $display("FAIL midreset_hilo: got %h expected 0", bus.HiLoData); end
        rst = 1'b0;
        dn  = 0;
        bz  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.Done) dn++;
            if (bus.Busy) bz++;
        end
        n_checks++; if (dn != 0 || bz != 0) begin n_fail++; $display("FAIL midreset_quiet: got done %0d busy %0d expected 0/0", dn, bz); end
        n_checks++; if (bus.HiLoData !== 64'd0) begin n_fail++; $display("FAIL midreset_hold: got %h expected 0", bus.HiLoData); end
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divide();
        test_div_zero();
        test_mthi_mtlo();
        test_stall();
        test_back_to_back();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
